// File: rtl/seq_divider_pkg.sv
// Shared constants and FSM state encoding for the sequential restoring divider.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor with a ripple-carry adder, restore on borrow.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] partial,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] new_partial,
    output logic             quotient_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   divisor_inv;
    logic [WIDTH+1:0] carry;
    logic [WIDTH-1:0] diff;

    assign shifted     = {partial, next_bit};
    assign divisor_inv = ~{1'b0, divisor};
    assign carry[0]    = 1'b1;

    // Subtract as shifted + ~divisor + 1; the carry out of the top bit means no borrow.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sum
            assign diff[gi] = shifted[gi] ^ divisor_inv[gi] ^ carry[gi];
        end
        for (gi = 0; gi <= WIDTH; gi++) begin : g_carry
            assign carry[gi+1] = (shifted[gi] & divisor_inv[gi])
                               | (carry[gi] & (shifted[gi] ^ divisor_inv[gi]));
        end
    endgenerate

    assign quotient_bit = carry[WIDTH+1];
    assign new_partial  = quotient_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: one restoring step per clock, WIDTH steps per
// division, with a divide-by-zero shortcut straight to FINISH.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] xin,
    input  logic [WIDTH-1:0] yin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divzero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] div_reg;
    logic [CW-1:0]    count_reg;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] step_quo;
    logic             last_step;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial      (rem_reg),
        .next_bit     (quo_reg[WIDTH-1]),
        .divisor      (div_reg),
        .new_partial  (step_rem),
        .quotient_bit (step_bit)
    );

    assign step_quo  = {quo_reg[WIDTH-2:0], step_bit};
    assign last_step = (count_reg == CW'(WIDTH - 1));
    assign accept    = (state_reg == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = (yin == '0) ? ST_FINISH : ST_RUN;
            ST_RUN:    if (last_step) state_next = ST_FINISH;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            ST_RUN:    busy = 1'b1;
            ST_FINISH: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default:   ;
        endcase
    end

    // Results are loaded on the edge entering FINISH so they are valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_reg   <= '0;
            quo_reg   <= '0;
            div_reg   <= '0;
            count_reg <= '0;
            quotient  <= '0;
            remainder <= '0;
            divzero   <= 1'b0;
        end else begin
            if (accept) begin
                div_reg   <= yin;
                quo_reg   <= xin;
                rem_reg   <= '0;
                count_reg <= '0;
                divzero   <= (yin == '0);
                if (yin == '0) begin
                    quotient  <= '1;
                    remainder <= xin;
                end
            end else if (state_reg == ST_RUN) begin
                rem_reg   <= step_rem;
                quo_reg   <= step_quo;
                count_reg <= count_reg + CW'(1);
                if (last_step) begin
                    quotient  <= step_quo;
                    remainder <= step_rem;
                end
            end
        end
    end

endmodule
